// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader: byte width and loader FSM states.
package instruction_loader_pkg;

   localparam int BYTE_SIZE = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RECEIVE,
      ST_WRITE,
      ST_DONE,
      ST_ERROR
   } state_t;

endpackage

// File: rtl/instruction_loader_word_packer.sv
// Shifts incoming bytes MSB-first into an instruction word and tracks the byte index.
// 'full' is high during the shift that completes the word.
module instruction_loader_word_packer
   import instruction_loader_pkg::*;
#(
   parameter int WORD_SIZE_IN_BYTES = 4
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     clear,
   input  logic                                     shift,
   input  logic [BYTE_SIZE-1:0]                     data,
   output logic [WORD_SIZE_IN_BYTES*BYTE_SIZE-1:0]  word,
   output logic                                     full
);

   localparam int WORD_BITS  = WORD_SIZE_IN_BYTES * BYTE_SIZE;
   localparam int INDEX_BITS = (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1;
   localparam logic [INDEX_BITS-1:0] LAST_INDEX = INDEX_BITS'(WORD_SIZE_IN_BYTES - 1);

   logic [INDEX_BITS-1:0] index;

   assign full = shift && (index == LAST_INDEX);

   // Index wraps on the completing byte so the next word starts cleanly
   always_ff @(posedge clk) begin
      if (reset) begin
         word  <= '0;
         index <= '0;
      end else if (clear) begin
         index <= '0;
      end else if (shift) begin
         word  <= {word[WORD_BITS-BYTE_SIZE-1:0], data};
         index <= full ? '0 : index + INDEX_BITS'(1);
      end
   end

endmodule

// File: rtl/instruction_loader.sv
// Loads a byte-streamed program into instruction memory: clears memory, packs bytes into
// words, strobes one write per word and stops on the HALT word or when memory is full.
module instruction_loader
   import instruction_loader_pkg::*;
#(
   parameter int WORD_SIZE_IN_BYTES = 4,
   parameter int MEM_SIZE_IN_WORDS  = 10,
   parameter logic [WORD_SIZE_IN_BYTES*BYTE_SIZE-1:0] HALT_INSTRUCTION = 'h1
) (
   input  logic                                       i_clk,
   input  logic                                       i_reset,
   input  logic                                       i_start,
   input  logic                                       i_byte_valid,
   input  logic [BYTE_SIZE-1:0]                       i_byte,
   output logic                                       o_byte_ready,
   output logic [WORD_SIZE_IN_BYTES*BYTE_SIZE-1:0]    o_instruction,
   output logic                                       o_instruction_write,
   output logic                                       o_clear_mem,
   output logic [$clog2(MEM_SIZE_IN_WORDS+1)-1:0]     o_word_count,
   output logic                                       o_loading,
   output logic                                       o_done,
   output logic                                       o_overflow
);

   localparam int COUNT_BITS = $clog2(MEM_SIZE_IN_WORDS + 1);
   localparam int WORD_BITS  = WORD_SIZE_IN_BYTES * BYTE_SIZE;
   localparam logic [COUNT_BITS-1:0] COUNT_MAX = COUNT_BITS'(MEM_SIZE_IN_WORDS);
   localparam logic [COUNT_BITS:0]   MEM_LIMIT = (COUNT_BITS + 1)'(MEM_SIZE_IN_WORDS);

   state_t                state;
   state_t                state_next;
   logic [COUNT_BITS-1:0] word_count;
   logic [WORD_BITS-1:0]  word;
   logic                  transfer;
   logic                  word_full;

   assign transfer = i_byte_valid && (state == ST_RECEIVE);

   instruction_loader_word_packer #(
      .WORD_SIZE_IN_BYTES(WORD_SIZE_IN_BYTES)
   ) u_word_packer (
      .clk   (i_clk),
      .reset (i_reset),
      .clear (state == ST_CLEAR),
      .shift (transfer),
      .data  (i_byte),
      .word  (word),
      .full  (word_full)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Count saturates at capacity and holds through DONE/ERROR until the next clear
   always_ff @(posedge i_clk) begin
      if (i_reset || (state == ST_CLEAR)) begin
         word_count <= '0;
      end else if ((state == ST_WRITE) && (word_count < COUNT_MAX)) begin
         word_count <= word_count + COUNT_BITS'(1);
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (i_start) state_next = ST_CLEAR;
         end
         ST_CLEAR: state_next = ST_RECEIVE;
         ST_RECEIVE: begin
            if (word_full) state_next = ST_WRITE;
         end
         ST_WRITE: begin
            // HALT wins even when it lands in the last free slot
            if (word == HALT_INSTRUCTION) begin
               state_next = ST_DONE;
            end else if (({1'b0, word_count} + (COUNT_BITS + 1)'(1)) == MEM_LIMIT) begin
               state_next = ST_ERROR;
            end else begin
               state_next = ST_RECEIVE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Moore outputs decoded straight from the state register
   assign o_byte_ready        = (state == ST_RECEIVE);
   assign o_instruction_write = (state == ST_WRITE);
   assign o_clear_mem         = (state == ST_CLEAR);
   assign o_loading           = (state == ST_CLEAR) || (state == ST_RECEIVE) || (state == ST_WRITE);
   assign o_done              = (state == ST_DONE);
   assign o_overflow          = (state == ST_ERROR);
   assign o_instruction       = word;
   assign o_word_count        = word_count;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: scoreboard of expected words, a memory model fed by
// the write/clear strobes, and checks of reset, HALT, overflow, gaps and mid-word reset.
module tb_instruction_loader;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_start = 1'b0;
   logic        i_byte_valid = 1'b0;
   logic [7:0]  i_byte = 8'h00;
   logic        o_byte_ready;
   logic [31:0] o_instruction;
   logic        o_instruction_write;
   logic        o_clear_mem;
   logic [3:0]  o_word_count;
   logic        o_loading;
   logic        o_done;
   logic        o_overflow;

   int tests = 0;
   int fails = 0;

   logic [31:0] exp_q[$];
   logic [31:0] sent_words[$];
   logic [31:0] mem_model[0:15];
   int          mem_ptr = 0;
   int          wr_cnt = 0;
   int          clr_cnt = 0;
   int          both_cnt = 0;

   instruction_loader dut (
      .i_clk               (i_clk),
      .i_reset             (i_reset),
      .i_start             (i_start),
      .i_byte_valid        (i_byte_valid),
      .i_byte              (i_byte),
      .o_byte_ready        (o_byte_ready),
      .o_instruction       (o_instruction),
      .o_instruction_write (o_instruction_write),
      .o_clear_mem         (o_clear_mem),
      .o_word_count        (o_word_count),
      .o_loading           (o_loading),
      .o_done              (o_done),
      .o_overflow          (o_overflow)
   );

   always #5 i_clk = ~i_clk;

   // Stand-in for instruction_memory: clear rewinds the pointer, each strobe stores a word
   always @(negedge i_clk) begin
      if (!i_reset) begin
         if (o_instruction_write) begin
            wr_cnt <= wr_cnt + 1;
            mem_model[mem_ptr[3:0]] <= o_instruction;
            mem_ptr <= mem_ptr + 1;
         end
         if (o_clear_mem) begin
            clr_cnt <= clr_cnt + 1;
            mem_ptr <= 0;
         end
         if (o_instruction_write && o_clear_mem) both_cnt <= both_cnt + 1;
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
      tests++;
      assert (observed === expected)
      else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", name, observed, expected);
      end
   endtask

   // Presents one byte after 'gap' idle cycles; accepted tells whether a transfer happened
   task automatic applyStimulus(input logic [7:0] b, input int gap, input int budget, output bit accepted);
      accepted = 1'b0;
      repeat (gap) @(negedge i_clk);
      i_byte_valid = 1'b1;
      i_byte = b;
      for (int k = 0; k < budget; k++) begin
         if (o_byte_ready) begin
            accepted = 1'b1;
            break;
         end
         @(negedge i_clk);
      end
      @(negedge i_clk);
      i_byte_valid = 1'b0;
   endtask

   task automatic sendWord(input logic [31:0] w, input int max_gap);
      bit ok;
      bit seen;
      logic [31:0] exp_w;
      exp_q.push_back(w);
      sent_words.push_back(w);
      for (int i = 3; i >= 0; i--) begin
         applyStimulus(w[i*8 +: 8], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0, 60, ok);
         if (!ok) checkOutput("byte_accept", 64'(ok), 64'(1));
      end
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (o_instruction_write) begin
            seen = 1'b1;
            break;
         end
         @(negedge i_clk);
      end
      checkOutput("write_strobe_seen", 64'(seen), 64'(1));
      if (seen && exp_q.size() > 0) begin
         exp_w = exp_q.pop_front();
         checkOutput("write_word", 64'(o_instruction), 64'(exp_w));
      end
      @(negedge i_clk);
   endtask

   task automatic startSession();
      @(negedge i_clk);
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      checkOutput("clear_pulse", 64'(o_clear_mem), 64'(1));
      checkOutput("clear_no_write", 64'(o_instruction_write), 64'(0));
      @(negedge i_clk);
      checkOutput("clear_one_cycle", 64'(o_clear_mem), 64'(0));
      checkOutput("ready_in_receive", 64'(o_byte_ready), 64'(1));
      checkOutput("count_cleared", 64'(o_word_count), 64'(0));
      sent_words.delete();
   endtask

   initial begin
      bit ok;
      int wr_snap;
      int clr_snap;
      logic [31:0] w;

      // Reset held for 5 cycles
      repeat (5) @(negedge i_clk);
      i_reset = 1'b0;
      @(negedge i_clk);
      checkOutput("reset_outputs",
         {o_byte_ready, o_instruction_write, o_clear_mem, o_loading, o_done, o_overflow},
         64'(0));
      checkOutput("reset_instruction", 64'(o_instruction), 64'(0));
      checkOutput("reset_count", 64'(o_word_count), 64'(0));

      // Session 1: DEADBEEF, two random words, then HALT
      startSession();
      sendWord(32'hDEAD_BEEF, 0);
      checkOutput("count_after_first", 64'(o_word_count), 64'(1));
      clr_snap = clr_cnt;
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      @(negedge i_clk);
      checkOutput("start_ignored_loading", 64'(o_loading), 64'(1));
      checkOutput("start_ignored_no_clear", 64'(clr_cnt), 64'(clr_snap));
      for (int n = 0; n < 2; n++) begin
         w = $urandom | 32'h0000_0100;
         sendWord(w, 0);
      end
      sendWord(32'h0000_0001, 0);
      checkOutput("halt_done", 64'(o_done), 64'(1));
      checkOutput("halt_count", 64'(o_word_count), 64'(4));
      checkOutput("halt_ready", 64'(o_byte_ready), 64'(0));
      checkOutput("halt_loading", 64'(o_loading), 64'(0));
      checkOutput("halt_writes", 64'(wr_cnt), 64'(4));

      // Session 2: ten non-HALT words fill memory
      startSession();
      checkOutput("done_cleared", 64'(o_done), 64'(0));
      wr_snap = wr_cnt;
      for (int n = 0; n < 10; n++) begin
         w = $urandom | 32'h0000_0100;
         sendWord(w, 3);
         if (n == 8) checkOutput("no_overflow_at_9", 64'(o_overflow), 64'(0));
      end
      checkOutput("overflow_flag", 64'(o_overflow), 64'(1));
      checkOutput("overflow_count", 64'(o_word_count), 64'(10));
      checkOutput("overflow_writes", 64'(wr_cnt - wr_snap), 64'(10));
      applyStimulus(8'hAA, 0, 20, ok);
      checkOutput("byte_11_rejected", 64'(ok), 64'(0));
      repeat (2) @(negedge i_clk);
      checkOutput("overflow_held", {o_overflow, o_word_count}, {1'b1, 4'd10});
      checkOutput("overflow_no_extra_write", 64'(wr_cnt - wr_snap), 64'(10));

      // Session 3: random gaps between bytes, then read back the memory model
      startSession();
      for (int n = 0; n < 3; n++) begin
         w = $urandom | 32'h0000_0100;
         sendWord(w, 20);
      end
      sendWord(32'h0000_0001, 20);
      checkOutput("gap_done", 64'(o_done), 64'(1));
      @(negedge i_clk);
      for (int a = 0; a < 4; a++) begin
         checkOutput($sformatf("mem_pc_%0d", a * 4), 64'(mem_model[a]), 64'(sent_words[a]));
      end

      // Session 4: reset after two bytes, then a clean session
      startSession();
      applyStimulus(8'h12, 0, 60, ok);
      applyStimulus(8'h34, 0, 60, ok);
      wr_snap = wr_cnt;
      clr_snap = clr_cnt;
      i_reset = 1'b1;
      @(negedge i_clk);
      i_reset = 1'b0;
      @(negedge i_clk);
      checkOutput("midreset_idle",
         {o_byte_ready, o_loading, o_done, o_overflow, o_instruction_write, o_clear_mem},
         64'(0));
      repeat (3) @(negedge i_clk);
      checkOutput("midreset_no_write", 64'(wr_cnt), 64'(wr_snap));
      checkOutput("midreset_no_clear", 64'(clr_cnt), 64'(clr_snap));
      startSession();
      sendWord(32'h0000_0001, 0);
      checkOutput("clean_session_done", {o_done, o_word_count}, {1'b1, 4'd1});

      checkOutput("write_clear_overlap", 64'(both_cnt), 64'(0));
      checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
